// File: rtl/mem_port_arbiter.sv
// Shares the single 64-bit data memory port between instruction fetch and load/store.
// One requester is granted at a time from idle; ties alternate. Misaligned data
// accesses are rejected with an error pulse instead of reaching memory.
module mem_port_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [31:0] o_if_data,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [63:0] i_d_addr,
  input  logic [63:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_valid,
  output logic [63:0] o_d_rdata,
  output logic        o_d_err,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic        o_mem_wr,
  input  logic [63:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [2:0] LatInit = 3'(READ_LAT);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_last_d;   // 1: data path was granted most recently
  logic [2:0]  r_cnt;
  logic        r_is_data;
  logic        r_we;
  logic        r_sel_hi;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic        r_mem_wr;
  logic [63:0] r_d_rdata;
  logic [31:0] r_if_data;
  logic        r_if_valid;
  logic        r_d_valid;
  logic        r_d_err;

  logic        w_idle;
  logic        w_pick_if;
  logic        w_pick_d;
  logic [63:0] w_req_addr;
  logic        w_misaligned;
  logic        w_issue;

  // Arbitration and grant outputs: grants only in idle, ties go to the one not served last.
  always_comb begin
    w_idle       = (r_state == StIdle) && !i_reset;
    w_pick_if    = w_idle && i_if_req && (!i_d_req || r_last_d);
    w_pick_d     = w_idle && i_d_req && (!i_if_req || !r_last_d);
    w_req_addr   = w_pick_d ? i_d_addr : {32'h0, i_if_addr};
    w_misaligned = w_pick_d && (w_req_addr[2:0] != 3'b000);
    w_issue      = (w_pick_if || w_pick_d) && !w_misaligned;
    o_if_gnt     = w_pick_if;
    o_d_gnt      = w_pick_d;
  end

  // Next-state logic: stores finish in ISSUE, reads wait out the memory latency.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_issue) w_state_next = StIssue;
      StIssue: w_state_next = r_we ? StIdle : StWait;
      StWait:  if (r_cnt == 3'd1) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Arbitration history and latency counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_d <= 1'b1;
      r_cnt    <= 3'd0;
    end else begin
      if (w_pick_if || w_pick_d) r_last_d <= w_pick_d;
      if (r_state == StIssue && !r_we) begin
        r_cnt <= LatInit;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Request latch and memory-side registers, loaded at the end of the grant cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_is_data   <= 1'b0;
      r_we        <= 1'b0;
      r_sel_hi    <= 1'b0;
      r_mem_addr  <= 64'h0;
      r_mem_wdata <= 64'h0;
      r_mem_wr    <= 1'b0;
    end else begin
      r_mem_wr <= 1'b0;
      if (w_issue) begin
        r_is_data  <= w_pick_d;
        r_we       <= w_pick_d && i_d_we;
        r_sel_hi   <= w_req_addr[2];
        r_mem_addr <= {w_req_addr[63:3], 3'b000};
        if (w_pick_d && i_d_we) begin
          r_mem_wdata <= i_d_wdata;
          r_mem_wr    <= 1'b1;
        end
      end
    end
  end

  // Completion pulses and returned data; read data is captured in the last WAIT cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      r_if_data  <= 32'h0;
      r_d_rdata  <= 64'h0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= w_misaligned;
      if (r_state == StIssue && r_we) r_d_valid <= 1'b1;
      if (r_state == StWait && r_cnt == 3'd1) begin
        if (r_is_data) begin
          r_d_rdata <= i_mem_rdata;
          r_d_valid <= 1'b1;
        end else begin
          r_if_data  <= r_sel_hi ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
          r_if_valid <= 1'b1;
        end
      end
    end
  end

  assign o_if_valid  = r_if_valid;
  assign o_if_data   = r_if_data;
  assign o_d_valid   = r_d_valid;
  assign o_d_rdata   = r_d_rdata;
  assign o_d_err     = r_d_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: grant table, directed corner sequences and a randomized
// run checked against a cycle-scheduled reference model.
module tb_mem_port_arbiter;

  localparam int NRAND = 1500;
  localparam int LAT = 1;

  logic clk, reset;
  logic if_req, if_gnt, if_valid;
  logic [31:0] if_addr, if_data;
  logic d_req, d_we, d_gnt, d_valid, d_err, mem_wr;
  logic [63:0] d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // Second instance with a longer read latency.
  logic e_if_req, e_if_gnt, e_if_valid;
  logic [31:0] e_if_addr, e_if_data;
  logic e_d_req, e_d_we, e_d_gnt, e_d_valid, e_d_err, e_mem_wr;
  logic [63:0] e_d_addr, e_d_wdata, e_d_rdata, e_mem_addr, e_mem_wdata, e_mem_rdata;

  int n_checks = 0;
  int n_fail = 0;

  mem_port_arbiter #(.READ_LAT(LAT)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_valid(if_valid),
    .o_if_data(if_data), .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_valid(d_valid), .o_d_rdata(d_rdata),
    .o_d_err(d_err), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wr(mem_wr),
    .i_mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.READ_LAT(3)) dut3 (
    .i_clk(clk), .i_reset(reset),
    .i_if_req(e_if_req), .i_if_addr(e_if_addr), .o_if_gnt(e_if_gnt),
    .o_if_valid(e_if_valid), .o_if_data(e_if_data), .i_d_req(e_d_req), .i_d_we(e_d_we),
    .i_d_addr(e_d_addr), .i_d_wdata(e_d_wdata), .o_d_gnt(e_d_gnt), .o_d_valid(e_d_valid),
    .o_d_rdata(e_d_rdata), .o_d_err(e_d_err), .o_mem_addr(e_mem_addr),
    .o_mem_wdata(e_mem_wdata), .o_mem_wr(e_mem_wr), .i_mem_rdata(e_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    e_d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic        exp_if_gnt;
    logic        exp_d_gnt;
    logic        exp_err;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [10];

  // Reference model state for the randomized run.
  logic [63:0] mem_hist [NRAND+8];
  bit exp_ifv [NRAND+8];
  bit exp_sel [NRAND+8];
  bit exp_dv  [NRAND+8];
  bit exp_dld [NRAND+8];
  bit exp_err [NRAND+8];
  bit exp_wr  [NRAND+8];

  initial begin
    logic [63:0] m_mem_addr, m_mem_wdata, m_d_rdata;
    logic [31:0] m_if_data;
    logic m_last_data, if_pend, d_pend, pick_if, pick_d;
    int free_at;

    reset = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    e_if_req = 1'b0; e_if_addr = '0; e_d_req = 1'b0; e_d_we = 1'b0; e_d_addr = '0;
    e_d_wdata = '0; e_mem_rdata = '0;

    // Fields: if_req if_addr d_req d_we d_addr | if_gnt d_gnt err wr
    vecs[0] = '{1'b1, 32'h4,  1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h8,  1'b1, 1'b0, 64'h8,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'hC,  1'b1, 1'b0, 64'h8,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 64'h13, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h10, 1'b1, 1'b1, 64'h21, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h14, 1'b1, 1'b1, 64'h20, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 64'h7,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'h18, 1'b1, 1'b0, 64'h1,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 32'h0,  1'b1, 1'b1, 64'h18, 1'b0, 1'b1, 1'b0, 1'b1};

    // Fetch after reset, upper word selected.
    do_reset();
    check("reset mem_wr", {63'h0, mem_wr}, 64'h0);
    check("reset if_valid", {63'h0, if_valid}, 64'h0);
    check("reset mem_addr", mem_addr, 64'h0);
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    check("fetch if_gnt", {63'h0, if_gnt}, 64'h1);
    check("fetch d_gnt", {63'h0, d_gnt}, 64'h0);
    @(negedge clk); if_req = 1'b0;
    check("fetch mem_addr", mem_addr, 64'h0);
    check("fetch mem_wr", {63'h0, mem_wr}, 64'h0);
    check("fetch G+1 if_valid", {63'h0, if_valid}, 64'h0);
    @(negedge clk);
    check("fetch G+2 if_valid", {63'h0, if_valid}, 64'h0);
    @(negedge clk);
    check("fetch G+3 if_valid", {63'h0, if_valid}, 64'h1);
    check("fetch if_data", {32'h0, if_data}, 64'hAAAA_BBBB);

    // Store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h10; d_wdata = 64'h1234;
    #1;
    check("store d_gnt", {63'h0, d_gnt}, 64'h1);
    @(negedge clk); d_req = 1'b0;
    check("store G+1 mem_wr", {63'h0, mem_wr}, 64'h1);
    check("store mem_addr", mem_addr, 64'h10);
    check("store mem_wdata", mem_wdata, 64'h1234);
    check("store G+1 d_valid", {63'h0, d_valid}, 64'h0);
    @(negedge clk);
    check("store G+2 mem_wr", {63'h0, mem_wr}, 64'h0);
    check("store G+2 d_valid", {63'h0, d_valid}, 64'h1);
    check("store G+2 if_valid", {63'h0, if_valid}, 64'h0);

    // Misaligned load, granted right in the store's dValid cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h13;
    #1;
    check("misal d_gnt", {63'h0, d_gnt}, 64'h1);
    @(negedge clk); d_req = 1'b0;
    check("misal d_err", {63'h0, d_err}, 64'h1);
    check("misal mem_wr", {63'h0, mem_wr}, 64'h0);
    check("misal mem_addr", mem_addr, 64'h10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("misal quiet %0d", k), {61'h0, d_valid, d_err, mem_wr}, 64'h0);
    end

    // Tie from reset: fetch first, data in the ifValid cycle, then fetch again.
    do_reset();
    mem_rdata = 64'h1122_3344_5566_7788;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8;
    #1;
    check("tie1 if_gnt", {63'h0, if_gnt}, 64'h1);
    check("tie1 d_gnt", {63'h0, d_gnt}, 64'h0);
    @(negedge clk); if_req = 1'b0;
    check("tie G+1 d_gnt", {63'h0, d_gnt}, 64'h0);
    @(negedge clk);
    check("tie G+2 d_gnt", {63'h0, d_gnt}, 64'h0);
    @(negedge clk);
    check("tie G+3 if_valid", {63'h0, if_valid}, 64'h1);
    check("tie G+3 d_gnt", {63'h0, d_gnt}, 64'h1);
    @(negedge clk); d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("tie load d_valid", {63'h0, d_valid}, 64'h1);
    check("tie load d_rdata", d_rdata, 64'h1122_3344_5566_7788);
    if_req = 1'b1; d_req = 1'b1;
    #1;
    check("tie2 if_gnt", {63'h0, if_gnt}, 64'h1);
    check("tie2 d_gnt", {63'h0, d_gnt}, 64'h0);
    @(negedge clk); if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the WAIT cycle of a load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8;
    #1;
    check("rst load d_gnt", {63'h0, d_gnt}, 64'h1);
    @(negedge clk); d_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst d_valid", {63'h0, d_valid}, 64'h0);
    check("rst flags", {58'h0, if_valid, d_err, mem_wr, if_gnt, d_gnt, 1'b0}, 64'h0);
    check("rst mem_addr", mem_addr, 64'h0);
    check("rst mem_wdata", mem_wdata, 64'h0);
    check("rst if_data", {32'h0, if_data}, 64'h0);
    check("rst d_rdata", d_rdata, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst after d_valid %0d", k), {63'h0, d_valid}, 64'h0);
    end
    mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    if_req = 1'b1; if_addr = 32'hC;
    #1;
    check("rst fetch if_gnt", {63'h0, if_gnt}, 64'h1);
    @(negedge clk); if_req = 1'b0;
    check("rst fetch mem_addr", mem_addr, 64'h8);
    repeat (2) @(negedge clk);
    check("rst fetch if_valid", {63'h0, if_valid}, 64'h1);
    check("rst fetch if_data", {32'h0, if_data}, 64'hDEAD_BEEF);

    // READ_LAT=3 load: dValid in G+5 carrying the G+4 memory data.
    e_d_req = 1'b1; e_d_we = 1'b0; e_d_addr = 64'h8; e_mem_rdata = 64'h0;
    #1;
    check("lat3 d_gnt", {63'h0, e_d_gnt}, 64'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e_d_req = 1'b0;
      if (k == 1) check("lat3 mem_addr", e_mem_addr, 64'h8);
      check($sformatf("lat3 G+%0d d_valid", k), {63'h0, e_d_valid}, {63'h0, k == 5});
      if (k == 5) check("lat3 d_rdata", e_d_rdata, 64'hC0DE_0000_0000_0004);
      e_mem_rdata = 64'hC0DE_0000_0000_0000 + 64'(k);
    end

    // Table of single-shot requests applied from idle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = 64'h5A5A_0000 + 64'(i);
      #1;
      check($sformatf("vec%0d if_gnt", i), {63'h0, if_gnt}, {63'h0, vecs[i].exp_if_gnt});
      check($sformatf("vec%0d d_gnt", i), {63'h0, d_gnt}, {63'h0, vecs[i].exp_d_gnt});
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0;
      check($sformatf("vec%0d d_err", i), {63'h0, d_err}, {63'h0, vecs[i].exp_err});
      check($sformatf("vec%0d mem_wr", i), {63'h0, mem_wr}, {63'h0, vecs[i].exp_wr});
      repeat (5) @(negedge clk);
    end

    // Randomized traffic against the scheduled model.
    do_reset();
    m_mem_addr = '0; m_mem_wdata = '0; m_d_rdata = '0; m_if_data = '0;
    m_last_data = 1'b1; if_pend = 1'b0; d_pend = 1'b0; free_at = 0;
    for (int t = 0; t < NRAND; t++) begin
      @(negedge clk);
      if (exp_ifv[t]) m_if_data = exp_sel[t] ? mem_hist[t-1][63:32] : mem_hist[t-1][31:0];
      if (exp_dld[t]) m_d_rdata = mem_hist[t-1];
      check("rnd if_valid", {63'h0, if_valid}, {63'h0, exp_ifv[t]});
      check("rnd d_valid", {63'h0, d_valid}, {63'h0, exp_dv[t]});
      check("rnd d_err", {63'h0, d_err}, {63'h0, exp_err[t]});
      check("rnd mem_wr", {63'h0, mem_wr}, {63'h0, exp_wr[t]});
      check("rnd mem_addr", mem_addr, m_mem_addr);
      check("rnd mem_wdata", mem_wdata, m_mem_wdata);
      check("rnd if_data", {32'h0, if_data}, {32'h0, m_if_data});
      check("rnd d_rdata", d_rdata, m_d_rdata);

      if (!if_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          if_pend = 1'b1;
          if_addr = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        if_pend = 1'b0;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          d_pend = 1'b1;
          d_we = 1'($urandom_range(0, 1));
          d_addr = {$urandom, $urandom};
          if ($urandom_range(0, 3) != 0) d_addr[2:0] = 3'b000;
          d_wdata = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 15) == 0) begin
        d_pend = 1'b0;
      end
      if_req = if_pend;
      d_req = d_pend;
      mem_rdata = {$urandom, $urandom};
      mem_hist[t] = mem_rdata;
      #1;

      pick_if = (t >= free_at) && if_pend && (!d_pend || m_last_data);
      pick_d = (t >= free_at) && d_pend && (!if_pend || !m_last_data);
      check("rnd if_gnt", {63'h0, if_gnt}, {63'h0, pick_if});
      check("rnd d_gnt", {63'h0, d_gnt}, {63'h0, pick_d});
      if (pick_if) begin
        m_last_data = 1'b0;
        m_mem_addr = {32'h0, if_addr[31:3], 3'b000};
        free_at = t + LAT + 2;
        exp_ifv[t+LAT+2] = 1'b1;
        exp_sel[t+LAT+2] = if_addr[2];
        if_pend = 1'b0;
      end else if (pick_d) begin
        m_last_data = 1'b1;
        d_pend = 1'b0;
        if (d_addr[2:0] != 3'b000) begin
          exp_err[t+1] = 1'b1;
          free_at = t + 1;
        end else if (d_we) begin
          m_mem_addr = {d_addr[63:3], 3'b000};
          m_mem_wdata = d_wdata;
          exp_wr[t+1] = 1'b1;
          exp_dv[t+2] = 1'b1;
          free_at = t + 2;
        end else begin
          m_mem_addr = {d_addr[63:3], 3'b000};
          exp_dv[t+LAT+2] = 1'b1;
          exp_dld[t+LAT+2] = 1'b1;
          free_at = t + LAT + 2;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
